// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the control-FSM state type.
// Used by the FIFO storage block, its control logic and the benches.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;

    // States of the button-driven control FSM that sits on the requester side.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } fifo_state_t;

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_core_if.sv
// FIFO control interface: requester (master) drives wen/ren/din,
// the storage block (slave) returns data, status and error flags.
interface fifo_core_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
);

    logic                  wen;
    logic                  ren;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wen,
        output ren,
        output din,
        input  dout,
        input  rd_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wen,
        input  ren,
        input  din,
        output dout,
        output rd_valid,
        output full,
        output empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read that holds its
// value between reads. Only the output register is reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_core.sv
// FIFO storage/pointer block: level wen/ren, one transfer per clock,
// registered full/empty/count, registered read data and sticky error flags.
module fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    fifo_core_if.slave bus
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  rd_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    always_comb begin
        rd_acc     = bus.ren & ~empty_reg;
        wr_acc     = bus.wen & (~full_reg | rd_acc);
        count_next = count_reg;
        if (wr_acc & ~rd_acc) begin
            count_next = count_reg + CNT_ONE;
        end else if (rd_acc & ~wr_acc) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Reset must block the RAM ports too, since the array itself is not reset.
    assign mem_we = wr_acc & ~reset;
    assign mem_re = rd_acc & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg    <= count_next;
            full_reg     <= (count_next == FULL_COUNT);
            empty_reg    <= (count_next == '0);
            rd_valid_reg <= rd_acc;
            if (bus.wen & ~wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (bus.ren & empty_reg) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clock),
        .srst  (reset),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.din),
        .re    (mem_re),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    assign bus.dout      = mem_rdata;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.full      = full_reg;
    assign bus.empty     = empty_reg;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_core.sv
// Directed bench for fifo_core: queue-based reference model compared every
// cycle, plus literal expectations from the hand-worked test plan.
module tb_fifo_core;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clock;
    logic reset;

    fifo_core_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv;
    logic          m_ovf;
    logic          m_unf;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit can_r;
        bit can_w;
        if (rs) begin
            q.delete();
            m_dout = '0;
            m_rv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            can_r = r && (q.size() > 0);
            can_w = w && ((q.size() < DEPTH) || can_r);
            if (r && q.size() == 0) m_unf = 1'b1;
            if (w && !can_w) m_ovf = 1'b1;
            if (can_r) begin
                m_dout = q.pop_front();
                m_rv   = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (can_w) q.push_back(d);
        end
    endtask

    // One clock of stimulus; model advances on the same edge as the DUT.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bus.wen = w;
        bus.ren = r;
        bus.din = d;
        reset   = rs;
        @(posedge clock);
        model_update(w, r, d, rs);
        #1;
        check_en = 1'b1;
        $display("[TB] wen=%0b ren=%0b din=%02h rst=%0b -> count=%0d dout=%02h rv=%0b full=%0b empty=%0b ovf=%0b unf=%0b",
                 w, r, d, rs, bus.count, bus.dout, bus.rd_valid, bus.full, bus.empty,
                 bus.overflow, bus.underflow);
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            cmp("dout",      32'(bus.dout),      32'(m_dout));
            cmp("rd_valid",  32'(bus.rd_valid),  32'(m_rv));
            cmp("count",     32'(bus.count),     32'(q.size()));
            cmp("full",      32'(bus.full),      32'(q.size() == DEPTH));
            cmp("empty",     32'(bus.empty),     32'(q.size() == 0));
            cmp("overflow",  32'(bus.overflow),  32'(m_ovf));
            cmp("underflow", 32'(bus.underflow), 32'(m_unf));
        end
    end

    initial begin
        logic [DW-1:0] v;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        bus.din = '0;
        reset   = 1'b1;
        m_dout  = '0;
        m_rv    = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset then idle
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        cmp("rst_empty", 32'(bus.empty), 32'd1);
        cmp("rst_full",  32'(bus.full),  32'd0);
        cmp("rst_count", 32'(bus.count), 32'd0);
        cmp("rst_dout",  32'(bus.dout),  32'd0);
        cmp("rst_rv",    32'(bus.rd_valid), 32'd0);
        cmp("rst_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

        // Fill and overfill
        for (int i = 0; i < 8; i++) begin
            v = 8'h11 + 8'(i);
            step(1'b1, 1'b0, v, 1'b0);
            cmp("fill_count", 32'(bus.count), 32'(i + 1));
        end
        cmp("fill_full", 32'(bus.full), 32'd1);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        cmp("ovf_flag",  32'(bus.overflow), 32'd1);
        cmp("ovf_count", 32'(bus.count), 32'd8);

        // Drain order, then read from empty
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("drain_dout", 32'(bus.dout), 32'(8'h11 + 8'(i)));
            cmp("drain_rv",   32'(bus.rd_valid), 32'd1);
        end
        cmp("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("unf_flag", 32'(bus.underflow), 32'd1);
        cmp("unf_rv",   32'(bus.rd_valid), 32'd0);
        cmp("unf_hold", 32'(bus.dout), 32'h18);

        // Wrap-around: pointers cross index 8 during the second batch
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("wrap1_dout", 32'(bus.dout), 32'(8'h50 + 8'(i)));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("wrap2_dout", 32'(bus.dout), 32'(8'hA0 + 8'(i)));
        end
        cmp("wrap_count", 32'(bus.count), 32'd0);

        // Simultaneous at empty: write only, no bypass to dout
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        cmp("sim_e_count", 32'(bus.count), 32'd1);
        cmp("sim_e_unf",   32'(bus.underflow), 32'd1);
        cmp("sim_e_rv",    32'(bus.rd_valid), 32'd0);
        cmp("sim_e_dout",  32'(bus.dout), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'hC1 + 8'(i), 1'b0);
        cmp("sim_f_pre", 32'(bus.full), 32'd1);

        // Simultaneous at full: oldest word out, new word into the freed slot
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        cmp("sim_f_count", 32'(bus.count), 32'd8);
        cmp("sim_f_dout",  32'(bus.dout), 32'h3C);
        cmp("sim_f_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("sim_f_drain", 32'(bus.dout), 32'(8'hC1 + 8'(i)));
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("sim_f_last", 32'(bus.dout), 32'hEE);

        // Reset mid-stream with wen high: nothing is written
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h61 + 8'(i), 1'b0);
        cmp("mid_pre_count", 32'(bus.count), 32'd4);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        cmp("mid_count", 32'(bus.count), 32'd0);
        cmp("mid_empty", 32'(bus.empty), 32'd1);
        cmp("mid_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("mid_rv",  32'(bus.rd_valid), 32'd0);
        cmp("mid_unf", 32'(bus.underflow), 32'd1);
        step(1'b1, 1'b0, 8'h88, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("mid_after", 32'(bus.dout), 32'h88);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        @(negedge clock);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
